// File: rtl/predistort_taps_source.sv
// Predistorter taps source: a settings-bus-written tap table streamed out as one
// AXI-stream packet of 2^DEPTH beats on command, with a skid stage for full-rate output.
module predistort_taps_source #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 7,
  parameter int unsigned SR_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  output logic [WIDTH-1:0] taps_tdata,
  output logic             taps_tlast,
  output logic             taps_tvalid,
  input  logic             taps_tready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N = 1 << DEPTH;
  localparam logic [7:0] ADDR_WADDR = 8'(SR_BASE);
  localparam logic [7:0] ADDR_WDATA = 8'(SR_BASE + 1);
  localparam logic [7:0] ADDR_CTRL  = 8'(SR_BASE + 2);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem [N];
  logic [DEPTH-1:0]   wptr;
  logic [DEPTH:0]     rd_idx;
  logic               rd_vld;
  logic               rd_last;
  logic [WIDTH-1:0]   mem_q;
  logic               sk_vld;
  logic               sk_last;
  logic [WIDTH-1:0]   sk_data;

  logic               sel_waddr, sel_wdata, sel_ctrl;
  logic               start_c, abort_c, kill_c, go_c, wr_en_c, xfer_c, rd_issue_c;
  logic [1:0]         occ_c;
  logic [DEPTH-1:0]   rd_addr_c;
  logic               unused_set_data;

  assign unused_set_data = ^set_data;

  // Settings decode; abort beats start, and table writes are locked out once a packet begins
  always_comb begin
    sel_waddr  = set_stb && (set_addr == ADDR_WADDR);
    sel_wdata  = set_stb && (set_addr == ADDR_WDATA);
    sel_ctrl   = set_stb && (set_addr == ADDR_CTRL);
    start_c    = sel_ctrl && set_data[0] && !set_data[1];
    abort_c    = sel_ctrl && set_data[1];
    kill_c     = (abort_c || clear) && (state != IDLE);
    go_c       = (state == IDLE) && start_c && !clear;
    wr_en_c    = sel_wdata && (state == IDLE);
    xfer_c     = taps_tvalid && taps_tready;
    // Entries held after this edge: output + skid + read in flight, minus the one leaving
    occ_c      = 2'(taps_tvalid) + 2'(sk_vld) + 2'(rd_vld) - 2'(xfer_c);
    rd_issue_c = go_c ||
                 ((state != IDLE) && !kill_c && !rd_idx[DEPTH] && (occ_c < 2'd2));
    rd_addr_c  = go_c ? '0 : rd_idx[DEPTH-1:0];
  end

  // Table storage with write-first bypass so a read of the entry being written sees new data
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wptr] <= set_data[WIDTH-1:0];
    if (rd_issue_c)
      mem_q <= (wr_en_c && (wptr == rd_addr_c)) ? set_data[WIDTH-1:0] : mem[rd_addr_c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wptr        <= '0;
      rd_idx      <= '0;
      rd_vld      <= 1'b0;
      rd_last     <= 1'b0;
      sk_vld      <= 1'b0;
      sk_last     <= 1'b0;
      sk_data     <= '0;
      taps_tdata  <= '0;
      taps_tlast  <= 1'b0;
      taps_tvalid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done   <= 1'b0;
      rd_vld <= rd_issue_c;

      if (clear)          wptr <= '0;
      else if (sel_waddr) wptr <= set_data[DEPTH-1:0];
      else if (wr_en_c)   wptr <= wptr + DEPTH'(1);

      if (rd_issue_c) begin
        rd_last <= (rd_addr_c == DEPTH'(N - 1));
        rd_idx  <= {1'b0, rd_addr_c} + (DEPTH + 1)'(1);
      end

      case (state)
        IDLE: if (go_c) begin
          state <= FETCH;
          busy  <= 1'b1;
        end
        FETCH: state <= SEND;
        SEND: if (xfer_c && taps_tlast) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Output stage refills from skid first, then from the read port
      if (!taps_tvalid || xfer_c) begin
        if (sk_vld) begin
          taps_tdata  <= sk_data;
          taps_tlast  <= sk_last;
          taps_tvalid <= 1'b1;
          sk_vld      <= rd_vld;
          if (rd_vld) begin
            sk_data <= mem_q;
            sk_last <= rd_last;
          end
        end else if (rd_vld) begin
          taps_tdata  <= mem_q;
          taps_tlast  <= rd_last;
          taps_tvalid <= 1'b1;
        end else begin
          taps_tvalid <= 1'b0;
          taps_tlast  <= 1'b0;
        end
      end else if (rd_vld) begin
        sk_vld  <= 1'b1;
        sk_data <= mem_q;
        sk_last <= rd_last;
      end

      if (kill_c) begin
        state       <= IDLE;
        busy        <= 1'b0;
        done        <= 1'b0;
        taps_tvalid <= 1'b0;
        taps_tlast  <= 1'b0;
        sk_vld      <= 1'b0;
        rd_vld      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_predistort_taps_source.sv
// Bench for predistort_taps_source: table model of the tap memory, packet scoreboard,
// control-decode vector table and hand sequences for wrap, lockout, abort, clear and reset.
module tb_predistort_taps_source;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 7;
  localparam int unsigned N     = 128;
  localparam logic [7:0] A_WADDR = 8'd0;
  localparam logic [7:0] A_WDATA = 8'd1;
  localparam logic [7:0] A_CTRL  = 8'd2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clear = 1'b0;
  logic             set_stb = 1'b0;
  logic [7:0]       set_addr = '0;
  logic [31:0]      set_data = '0;
  logic [WIDTH-1:0] taps_tdata;
  logic             taps_tlast;
  logic             taps_tvalid;
  logic             taps_tready = 1'b1;
  logic             busy;
  logic             done;

  predistort_taps_source #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SR_BASE(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .taps_tdata(taps_tdata), .taps_tlast(taps_tlast), .taps_tvalid(taps_tvalid),
    .taps_tready(taps_tready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        l;
    int          c;
  } beat_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        exp_busy;
  } ctrl_vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  beat_t       beats[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          stab_viol = 0;
  bit          stab_en = 1'b0;
  bit          rand_rdy = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [15:0] prev_d = '0;

  // Reference: the table contents and write pointer as the settings writes define them
  logic [15:0] mtbl [N];
  int          mptr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record transferred beats and done pulses; watch hold-while-stalled
  always @(negedge clk) begin
    if (reset) begin
      if (taps_tvalid && taps_tready) beats.push_back('{taps_tdata, taps_tlast, cyc});
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (stab_en && prev_v && !prev_r &&
          !(taps_tvalid && taps_tdata == prev_d && taps_tlast == prev_l))
        stab_viol = stab_viol + 1;
    end
    prev_v = taps_tvalid;
    prev_r = taps_tready;
    prev_d = taps_tdata;
    prev_l = taps_tlast;
  end

  initial forever begin
    @(posedge clk);
    #1;
    taps_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sr(input logic [7:0] a, input logic [31:0] d, input bit upd);
    set_stb = 1'b1; set_addr = a; set_data = d;
    tick();
    set_stb = 1'b0; set_addr = '0; set_data = '0;
    if (a == A_WADDR) mptr = int'(d[6:0]);
    else if (a == A_WDATA && upd) begin
      mtbl[mptr] = d[15:0];
      mptr = (mptr + 1) % N;
    end
  endtask

  task automatic load_table(input bit ramp);
    sr(A_WADDR, 32'd0, 1'b1);
    for (int k = 0; k < N; k++)
      sr(A_WDATA, ramp ? 32'(k * 256) : 32'($urandom), 1'b1);
  endtask

  task automatic start_pkt();
    beats.delete();
    sr(A_CTRL, 32'd1, 1'b1);
  endtask

  task automatic wait_done(input string name, input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 2000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic wait_beats(input int n);
    int t = 0;
    while (beats.size() < n && t < 1000) begin
      tick();
      t++;
    end
  endtask

  task automatic check_pkt(input string name);
    check({name, "_beat_count"}, 32'(beats.size()), 32'(N));
    for (int i = 0; i < beats.size() && i < N; i++) begin
      check($sformatf("%s_data%0d", name, i), 32'(beats[i].d), 32'(mtbl[i]));
      check($sformatf("%s_last%0d", name, i), 32'(beats[i].l), 32'(i == N - 1));
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_tvalid"}, 32'(taps_tvalid), 32'd0);
    check({name, "_tlast"},  32'(taps_tlast),  32'd0);
    check({name, "_busy"},   32'(busy),        32'd0);
  endtask

  initial begin
    ctrl_vec_t vecs[6];
    int        d0;
    int        nlast;
    logic [15:0] old5;
    logic [15:0] first;

    vecs[0] = '{8'h02, 32'h0000_0000, 1'b0};
    vecs[1] = '{8'h02, 32'h0000_0002, 1'b0};
    vecs[2] = '{8'h02, 32'h0000_0003, 1'b0};
    vecs[3] = '{8'h03, 32'h0000_0001, 1'b0};
    vecs[4] = '{8'h12, 32'h0000_0001, 1'b0};
    vecs[5] = '{8'h02, 32'hFFFF_FFF5, 1'b1};

    // Reset state
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_tdata", 32'(taps_tdata), 32'd0);
    check("reset_done",  32'(done),       32'd0);
    reset = 1'b1;
    tick();

    // 1. Ramp at full rate with first-beat latency
    load_table(1'b1);
    d0 = done_cnt;
    start_pkt();
    check("ramp_busy_t1",   32'(busy),        32'd1);
    check("ramp_tvalid_t1", 32'(taps_tvalid), 32'd0);
    tick();
    check("ramp_tvalid_t2", 32'(taps_tvalid), 32'd1);
    check("ramp_tdata_t2",  32'(taps_tdata),  32'h0000);
    wait_done("ramp", d0);
    check_pkt("ramp");
    if (beats.size() == N) begin
      check("ramp_span", 32'(beats[N-1].c - beats[0].c), 32'(N - 1));
      check("ramp_done_lat", 32'(done_cyc - beats[N-1].c), 32'd1);
    end else check("ramp_size_for_timing", 32'(beats.size()), 32'(N));
    check_idle_outputs("ramp_end");

    // 2. Backpressure, same table
    rand_rdy = 1'b1; stab_en = 1'b1; stab_viol = 0;
    d0 = done_cnt;
    start_pkt();
    wait_done("bp", d0);
    check_pkt("bp");
    check("bp_stable", 32'(stab_viol), 32'd0);
    rand_rdy = 1'b0; stab_en = 1'b0;
    tick();

    // 3. Pointer wrap
    sr(A_WADDR, 32'd126, 1'b1);
    sr(A_WDATA, 32'hAAAA, 1'b1);
    sr(A_WDATA, 32'hBBBB, 1'b1);
    sr(A_WDATA, 32'hCCCC, 1'b1);
    d0 = done_cnt;
    start_pkt();
    wait_done("wrap", d0);
    check_pkt("wrap");
    first = (beats.size() > 0) ? beats[0].d : 16'hxxxx;
    check("wrap_first", 32'(first), 32'h0000CCCC);

    // 4. Lockout while busy
    old5 = mtbl[5];
    d0 = done_cnt;
    start_pkt();
    repeat (3) tick();
    sr(A_WADDR, 32'd5, 1'b1);
    sr(A_WDATA, 32'h1234, 1'b0);
    sr(A_CTRL, 32'd1, 1'b1);
    wait_done("lock", d0);
    check_pkt("lock");
    d0 = done_cnt;
    start_pkt();
    wait_done("lock2", d0);
    check_pkt("lock2");
    first = (beats.size() > 5) ? beats[5].d : 16'hxxxx;
    check("lock2_entry5", 32'(first), 32'(old5));

    // 5. Abort after 40 beats, then full replay
    d0 = done_cnt;
    start_pkt();
    wait_beats(40);
    sr(A_CTRL, 32'd2, 1'b1);
    check_idle_outputs("abort");
    repeat (4) tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_beats", 32'(beats.size()), 32'd41);
    nlast = 0;
    for (int i = 0; i < beats.size(); i++) begin
      if (beats[i].l) nlast++;
      if (i < N) check($sformatf("abort_data%0d", i), 32'(beats[i].d), 32'(mtbl[i]));
    end
    check("abort_no_tlast", 32'(nlast), 32'd0);
    d0 = done_cnt;
    start_pkt();
    wait_done("replay", d0);
    check_pkt("replay");

    // Clear mid-packet also zeroes the write pointer
    d0 = done_cnt;
    start_pkt();
    repeat (10) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    mptr = 0;
    check_idle_outputs("clear");
    sr(A_WDATA, 32'h5A5A, 1'b1);
    check("clear_no_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    start_pkt();
    wait_done("clear_pkt", d0);
    check_pkt("clear_pkt");

    // Control decode vectors
    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      beats.delete();
      sr(vecs[v].addr, vecs[v].data, 1'b1);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].exp_busy));
      if (vecs[v].exp_busy) begin
        wait_done($sformatf("vec%0d", v), d0);
        check_pkt($sformatf("vec%0d", v));
      end else begin
        repeat (3) tick();
        check($sformatf("vec%0d_nobeats", v), 32'(beats.size()), 32'd0);
      end
    end

    // 6. Reset mid-packet, then rewrite and replay under backpressure
    load_table(1'b0);
    d0 = done_cnt;
    start_pkt();
    wait_beats(60);
    reset = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check("midrst_tdata", 32'(taps_tdata), 32'd0);
    check("midrst_done",  32'(done),       32'd0);
    repeat (3) tick();
    reset = 1'b1;
    mptr = 0;
    tick();
    load_table(1'b0);
    rand_rdy = 1'b1;
    d0 = done_cnt;
    start_pkt();
    wait_done("postrst", d0);
    check_pkt("postrst");
    rand_rdy = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/predistort_taps_source.md
Name: predistort_taps_source

Overview:
- Transmitter end of the predistorter taps stream.
- Holds a 2^DEPTH-entry tap table written over the settings bus.
- On command, streams the whole table as one AXI-stream packet: entry 0 first, tlast on the final entry.
- Sits between the control/settings path and the taps_* input of predistort, so the taps table can be reloaded at run time without a testbench driver.

Parameters:
- WIDTH, 16, tap word width; equals predistort WIDTH.
- DEPTH, 7, log2 of table entries (128 by default); equals predistort DEPTH.
- SR_BASE, 0, base settings-register address.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- clear  in  1  synchronous clear; same effect as abort, and also zeroes the write pointer.
- set_stb  in  1  settings-bus write strobe.
- set_addr  in  8  settings-bus address.
- set_data  in  32  settings-bus data.
- taps_tdata  out  WIDTH  tap value.
- taps_tlast  out  1  high on the entry 2^DEPTH-1 beat.
- taps_tvalid  out  1  AXI-stream valid.
- taps_tready  in  1  AXI-stream ready.
- busy  out  1  high while a packet is in progress.
- done  out  1  one-cycle pulse after the last beat transfers.

Behaviour:
- Reset (async assert, sync release):
  - outputs: taps_tvalid=0, taps_tlast=0, taps_tdata=0, busy=0, done=0.
  - write pointer = 0, state = IDLE.
  - table contents undefined.
- Settings registers, acted on only when set_stb=1 and set_addr matches:
  - SR_BASE+0, WADDR: write pointer <= set_data[DEPTH-1:0].
  - SR_BASE+1, WDATA: table[ptr] <= set_data[WIDTH-1:0]; ptr <= ptr+1, wrapping 2^DEPTH-1 -> 0.
  - SR_BASE+2, CTRL: bit0 = start, bit1 = abort. If both bits are set, abort wins.
- Table writes are honoured only in IDLE. WDATA writes in FETCH or SEND are ignored and the pointer does not advance. WADDR is always honoured.
- FSM:
  - IDLE:
    - start -> FETCH with read index 0; busy=1 from the next cycle.
    - abort in IDLE: no effect.
  - FETCH:
    - synchronous table read takes one cycle; then the output register loads -> SEND.
    - first taps_tvalid rises 2 cycles after the start strobe cycle.
  - SEND:
    - taps_tvalid=1. taps_tdata and taps_tlast stay stable until the beat transfers (tvalid & tready).
    - On transfer, the next entry is presented the following cycle with no bubble. A prefetch/skid register is required so that tready held high gives 1 beat/clk.
    - Transfer of the tlast beat -> IDLE. That same edge sets tvalid=0, busy=0, done=1 for one cycle.
  - A packet is always exactly 2^DEPTH beats. tlast is high only on the beat carrying index 2^DEPTH-1.
  - Start while busy: ignored.
- Abort or clear in FETCH/SEND:
  - next cycle: tvalid=0, tlast=0, busy=0, state IDLE; done not pulsed.
  - the packet is truncated with no tlast, so the consumer must be cleared alongside.
  - If a beat transfers in the abort cycle, it counts as transferred.
- Simultaneous WDATA and start in IDLE: the write completes first, and the read for index 0 sees the new value when ptr was 0.
- Reset asserted mid-packet: tvalid drops immediately (asynchronous).
- tready low for any number of cycles: outputs hold and no beat is lost or duplicated.

Test Plan:
1. Ramp packet at full rate.
   - Stimulus: WADDR=0, then 128 WDATA writes of k*0x100 (k=0..127); start with tready=1.
   - Response: beats 0x0000..0x7F00 in order on 128 consecutive cycles; tlast only on 0x7F00; done 1 cycle after; first tvalid 2 cycles after start.
2. Backpressure.
   - Stimulus: same table; tready toggled pseudo-randomly at 50%.
   - Response: exactly 128 beats, identical sequence, tdata/tlast stable while tvalid=1 and tready=0.
3. Pointer wrap.
   - Stimulus: WADDR=126, then WDATA 0xAAAA, 0xBBBB, 0xCCCC; start.
   - Response: entries 126=0xAAAA, 127=0xBBBB, 0=0xCCCC; packet starts with 0xCCCC.
4. Lockout while busy.
   - Stimulus: during SEND, WDATA 0x1234 at ptr 5 and a second start.
   - Response: packet unchanged; a subsequent start shows the old entry 5; exactly one done per packet.
5. Abort.
   - Stimulus: abort after 40 beats.
   - Response: tvalid=0 next cycle, no tlast, no done, busy=0. A new start replays from entry 0 with the full 128 beats.
6. Reset mid-packet.
   - Stimulus: reset=0 at beat 60, then release; rewrite the table; start.
   - Response: all outputs 0 during reset; next packet complete and correct.
